// File: rtl/lsu_mem_stage_pkg.sv
// Shared definitions for the load/store stage.
//   - memory access size encodings
//   - trap cause codes raised by the stage
//   - stage state encoding
//   - write-back payload bundle and small lane helpers
package lsu_mem_stage_pkg;

  typedef enum logic [1:0] {
    MemB = 2'd0,
    MemH = 2'd1,
    MemW = 2'd2,
    MemD = 2'd3
  } mem_size_e;

  localparam logic [63:0] CauseLoadMisaligned  = 64'd4;
  localparam logic [63:0] CauseLoadAccFault    = 64'd5;
  localparam logic [63:0] CauseStoreMisaligned = 64'd6;
  localparam logic [63:0] CauseStoreAccFault   = 64'd7;

  // "Done" is not a state of its own: it is StIdle with the output slot occupied.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StResp  = 2'd2,
    StDrain = 2'd3
  } lsu_state_e;

  typedef struct packed {
    logic [63:0] pc;
    logic [63:0] next_pc;
    logic [31:0] inst;
    logic        trap_valid;
    logic        mret_valid;
    logic        sret_valid;
    logic [63:0] trap_cause;
    logic [63:0] trap_tval;
    logic        csr_wen;
    logic        csr_ren;
    logic [11:0] csr_addr;
    logic [4:0]  rd;
    logic        dest_wen;
    logic [63:0] data;
  } wb_payload_t;

  // Low address bits must be zero for the access size; bytes are always aligned.
  function automatic logic is_misaligned(logic [2:0] addr_lo, logic [1:0] size);
    logic mis;
    case (size)
      MemH:    mis = addr_lo[0];
      MemW:    mis = |addr_lo[1:0];
      MemD:    mis = |addr_lo;
      default: mis = 1'b0;
    endcase
    return mis;
  endfunction

  function automatic logic [7:0] size_mask(logic [1:0] size);
    logic [7:0] m;
    case (size)
      MemH:    m = 8'h03;
      MemW:    m = 8'h0F;
      MemD:    m = 8'hFF;
      default: m = 8'h01;
    endcase
    return m;
  endfunction

  // Replicating the store operand puts it on every lane; wstrb picks the right one.
  function automatic logic [63:0] lane_replicate(logic [63:0] d, logic [1:0] size);
    logic [63:0] r;
    case (size)
      MemH:    r = {4{d[15:0]}};
      MemW:    r = {2{d[31:0]}};
      MemD:    r = d;
      default: r = {8{d[7:0]}};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Load data alignment: shifts the 64-bit response right by the byte offset and
// sign- or zero-extends the selected width.
//   resp_data      raw 64-bit memory response
//   addr_lo        byte offset within the doubleword
//   mem_size       0=B 1=H 2=W 3=D
//   load_unsigned  zero-extend when set
//   load_data      aligned, extended result
module lsu_load_align
  import lsu_mem_stage_pkg::*;
(
  input  logic [63:0] resp_data,
  input  logic [2:0]  addr_lo,
  input  logic [1:0]  mem_size,
  input  logic        load_unsigned,
  output logic [63:0] load_data
);

  logic [63:0] shifted;

  always_comb begin
    shifted   = resp_data >> {addr_lo, 3'b000};
    load_data = shifted;
    case (mem_size)
      MemB: load_data = load_unsigned ? {56'd0, shifted[7:0]}
                                      : {{56{shifted[7]}}, shifted[7:0]};
      MemH: load_data = load_unsigned ? {48'd0, shifted[15:0]}
                                      : {{48{shifted[15]}}, shifted[15:0]};
      MemW: load_data = load_unsigned ? {32'd0, shifted[31:0]}
                                      : {{32{shifted[31]}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

endmodule

// File: rtl/lsu_mem_stage.sv
// Load/store pipeline stage between execute and write-back.
// Accepts one instruction from EX_LS, performs at most one data-memory access on a
// valid/ready request + response bus, aligns load data, raises misaligned and
// access-fault traps, and presents the result on the LS_WB register.
//   clk, rst_n          clock, asynchronous active-low reset
//   EX_LS_reg_*         incoming instruction fields; LS_EX_execute_ready back-pressure
//   lsu_req_* / lsu_resp_*  data-memory bus
//   LS_WB_reg_*         outgoing instruction fields; WB_LS_ls_ready, WB_LS_flush_flag
// Optional: define LSU_STAT_CNT_EN to add lsu_load_cnt, lsu_store_cnt, lsu_stall_cnt.
module lsu_mem_stage
  import lsu_mem_stage_pkg::*;
#(
  parameter logic [63:0] RST_PC = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        EX_LS_reg_execute_valid,
  output logic        LS_EX_execute_ready,
  input  logic [63:0] EX_LS_reg_PC,
  input  logic [63:0] EX_LS_reg_next_PC,
  input  logic [31:0] EX_LS_reg_inst,
  input  logic        EX_LS_reg_trap_valid,
  input  logic        EX_LS_reg_mret_valid,
  input  logic        EX_LS_reg_sret_valid,
  input  logic [63:0] EX_LS_reg_trap_cause,
  input  logic [63:0] EX_LS_reg_trap_tval,
  input  logic        EX_LS_reg_csr_wen,
  input  logic        EX_LS_reg_csr_ren,
  input  logic [11:0] EX_LS_reg_csr_addr,
  input  logic [4:0]  EX_LS_reg_rd,
  input  logic        EX_LS_reg_dest_wen,
  input  logic [63:0] EX_LS_reg_data,
  input  logic        EX_LS_reg_load_valid,
  input  logic        EX_LS_reg_store_valid,
  input  logic [1:0]  EX_LS_reg_mem_size,
  input  logic        EX_LS_reg_load_unsigned,
  input  logic [63:0] EX_LS_reg_store_data,
  output logic        lsu_req_valid,
  input  logic        lsu_req_ready,
  output logic [63:0] lsu_req_addr,
  output logic        lsu_req_wen,
  output logic [63:0] lsu_req_wdata,
  output logic [7:0]  lsu_req_wstrb,
  input  logic        lsu_resp_valid,
  input  logic [63:0] lsu_resp_data,
  input  logic        lsu_resp_error,
  output logic        LS_WB_reg_ls_valid,
  input  logic        WB_LS_ls_ready,
  input  logic        WB_LS_flush_flag,
  output logic [63:0] LS_WB_reg_PC,
  output logic [63:0] LS_WB_reg_next_PC,
  output logic [31:0] LS_WB_reg_inst,
  output logic        LS_WB_reg_trap_valid,
  output logic        LS_WB_reg_mret_valid,
  output logic        LS_WB_reg_sret_valid,
  output logic [63:0] LS_WB_reg_trap_cause,
  output logic [63:0] LS_WB_reg_trap_tval,
  output logic        LS_WB_reg_csr_wen,
  output logic        LS_WB_reg_csr_ren,
  output logic [11:0] LS_WB_reg_csr_addr,
  output logic [4:0]  LS_WB_reg_rd,
  output logic        LS_WB_reg_dest_wen,
  output logic [63:0] LS_WB_reg_data
`ifdef LSU_STAT_CNT_EN
  ,
  output logic [63:0] lsu_load_cnt,
  output logic [63:0] lsu_store_cnt,
  output logic [63:0] lsu_stall_cnt
`endif
);

  localparam wb_payload_t WbReset = '{pc: RST_PC, next_pc: RST_PC, default: '0};

  lsu_state_e  state_q, state_d;
  logic        ls_valid_q, ls_valid_d;
  wb_payload_t wb_q, wb_d;

  // Access context held from acceptance until the response returns.
  logic        is_load_q, is_load_d;
  logic [1:0]  size_q, size_d;
  logic        unsigned_q, unsigned_d;
  logic [63:0] addr_q, addr_d;
  logic        wen_q, wen_d;
  logic [63:0] wdata_q, wdata_d;
  logic [7:0]  wstrb_q, wstrb_d;

  logic        accept;
  logic        mem_op;
  logic        misaligned;
  logic [63:0] load_data;

  lsu_load_align u_load_align (
    .resp_data     (lsu_resp_data),
    .addr_lo       (addr_q[2:0]),
    .mem_size      (size_q),
    .load_unsigned (unsigned_q),
    .load_data     (load_data)
  );

  assign LS_EX_execute_ready = (state_q == StIdle) && !ls_valid_q;
  assign accept     = EX_LS_reg_execute_valid && LS_EX_execute_ready && !WB_LS_flush_flag;
  assign mem_op     = EX_LS_reg_load_valid || EX_LS_reg_store_valid;
  assign misaligned = is_misaligned(EX_LS_reg_data[2:0], EX_LS_reg_mem_size);

  always_comb begin
    state_d    = state_q;
    ls_valid_d = ls_valid_q;
    wb_d       = wb_q;
    is_load_d  = is_load_q;
    size_d     = size_q;
    unsigned_d = unsigned_q;
    addr_d     = addr_q;
    wen_d      = wen_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;

    unique case (state_q)
      StIdle: begin
        if (ls_valid_q && (WB_LS_ls_ready || WB_LS_flush_flag)) begin
          ls_valid_d = 1'b0;
        end
        // accept implies the output slot is empty, so this never races the clear above
        if (accept) begin
          wb_d.pc         = EX_LS_reg_PC;
          wb_d.next_pc    = EX_LS_reg_next_PC;
          wb_d.inst       = EX_LS_reg_inst;
          wb_d.trap_valid = EX_LS_reg_trap_valid;
          wb_d.mret_valid = EX_LS_reg_mret_valid;
          wb_d.sret_valid = EX_LS_reg_sret_valid;
          wb_d.trap_cause = EX_LS_reg_trap_cause;
          wb_d.trap_tval  = EX_LS_reg_trap_tval;
          wb_d.csr_wen    = EX_LS_reg_csr_wen;
          wb_d.csr_ren    = EX_LS_reg_csr_ren;
          wb_d.csr_addr   = EX_LS_reg_csr_addr;
          wb_d.rd         = EX_LS_reg_rd;
          wb_d.dest_wen   = EX_LS_reg_dest_wen && !EX_LS_reg_store_valid;
          wb_d.data       = EX_LS_reg_data;
          if (!mem_op || EX_LS_reg_trap_valid) begin
            ls_valid_d = 1'b1;
          end else if (misaligned) begin
            ls_valid_d      = 1'b1;
            wb_d.trap_valid = 1'b1;
            wb_d.trap_cause = EX_LS_reg_load_valid ? CauseLoadMisaligned : CauseStoreMisaligned;
            wb_d.trap_tval  = EX_LS_reg_data;
            wb_d.dest_wen   = 1'b0;
          end else begin
            state_d    = StReq;
            is_load_d  = EX_LS_reg_load_valid;
            size_d     = EX_LS_reg_mem_size;
            unsigned_d = EX_LS_reg_load_unsigned;
            addr_d     = EX_LS_reg_data;
            wen_d      = EX_LS_reg_store_valid;
            wdata_d    = lane_replicate(EX_LS_reg_store_data, EX_LS_reg_mem_size);
            wstrb_d    = size_mask(EX_LS_reg_mem_size) << EX_LS_reg_data[2:0];
          end
        end
      end
      StReq: begin
        if (WB_LS_flush_flag) begin
          // A handshake in the flush cycle has reached memory, so its response must be eaten.
          state_d = lsu_req_ready ? StDrain : StIdle;
        end else if (lsu_req_ready) begin
          state_d = StResp;
        end
      end
      StResp: begin
        if (WB_LS_flush_flag) begin
          state_d = lsu_resp_valid ? StIdle : StDrain;
        end else if (lsu_resp_valid) begin
          state_d    = StIdle;
          ls_valid_d = 1'b1;
          if (lsu_resp_error) begin
            wb_d.trap_valid = 1'b1;
            wb_d.trap_cause = is_load_q ? CauseLoadAccFault : CauseStoreAccFault;
            wb_d.trap_tval  = addr_q;
            wb_d.dest_wen   = 1'b0;
          end else if (is_load_q) begin
            wb_d.data = load_data;
          end
        end
      end
      StDrain: begin
        if (lsu_resp_valid) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      ls_valid_q <= 1'b0;
      wb_q       <= WbReset;
      is_load_q  <= 1'b0;
      size_q     <= 2'd0;
      unsigned_q <= 1'b0;
      addr_q     <= 64'd0;
      wen_q      <= 1'b0;
      wdata_q    <= 64'd0;
      wstrb_q    <= 8'd0;
    end else begin
      state_q    <= state_d;
      ls_valid_q <= ls_valid_d;
      wb_q       <= wb_d;
      is_load_q  <= is_load_d;
      size_q     <= size_d;
      unsigned_q <= unsigned_d;
      addr_q     <= addr_d;
      wen_q      <= wen_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
    end
  end

  assign lsu_req_valid = (state_q == StReq);
  assign lsu_req_addr  = addr_q;
  assign lsu_req_wen   = wen_q;
  assign lsu_req_wdata = wdata_q;
  assign lsu_req_wstrb = wstrb_q;

  assign LS_WB_reg_ls_valid   = ls_valid_q;
  assign LS_WB_reg_PC         = wb_q.pc;
  assign LS_WB_reg_next_PC    = wb_q.next_pc;
  assign LS_WB_reg_inst       = wb_q.inst;
  assign LS_WB_reg_trap_valid = wb_q.trap_valid;
  assign LS_WB_reg_mret_valid = wb_q.mret_valid;
  assign LS_WB_reg_sret_valid = wb_q.sret_valid;
  assign LS_WB_reg_trap_cause = wb_q.trap_cause;
  assign LS_WB_reg_trap_tval  = wb_q.trap_tval;
  assign LS_WB_reg_csr_wen    = wb_q.csr_wen;
  assign LS_WB_reg_csr_ren    = wb_q.csr_ren;
  assign LS_WB_reg_csr_addr   = wb_q.csr_addr;
  assign LS_WB_reg_rd         = wb_q.rd;
  assign LS_WB_reg_dest_wen   = wb_q.dest_wen;
  assign LS_WB_reg_data       = wb_q.data;

`ifdef LSU_STAT_CNT_EN
  logic [63:0] load_cnt_q, store_cnt_q, stall_cnt_q;
  logic        access_ok;

  assign access_ok = (state_q == StResp) && lsu_resp_valid && !lsu_resp_error &&
                     !WB_LS_flush_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_cnt_q  <= 64'd0;
      store_cnt_q <= 64'd0;
      stall_cnt_q <= 64'd0;
    end else begin
      if (access_ok && is_load_q)  load_cnt_q  <= load_cnt_q + 64'd1;
      if (access_ok && !is_load_q) store_cnt_q <= store_cnt_q + 64'd1;
      if ((state_q == StReq) || (state_q == StResp)) stall_cnt_q <= stall_cnt_q + 64'd1;
    end
  end

  assign lsu_load_cnt  = load_cnt_q;
  assign lsu_store_cnt = store_cnt_q;
  assign lsu_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: doc/lsu_mem_stage.md
Name: lsu_mem_stage

Overview:
- Load/store stage between execute and write-back.
- Accepts one instruction at a time from the EX_LS pipeline register and performs at most one data-memory access over a valid/ready request/response bus.
- Aligns and sign-extends load data; raises misaligned/access-fault traps.
- Drives the LS_WB pipeline register consumed by the write-back unit (PC, inst, trap, CSR, GPR fields).

Parameters:
- RST_PC, 64'h0, reset value of LS_WB_reg_PC and LS_WB_reg_next_PC.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- EX_LS_reg_execute_valid  in  1  EX has a valid instruction
- LS_EX_execute_ready  out  1  stage can accept (state IDLE and output slot free)
- EX_LS_reg_PC, EX_LS_reg_next_PC  in  64 each  instruction PC / next PC
- EX_LS_reg_inst  in  32  instruction word
- EX_LS_reg_trap_valid, EX_LS_reg_mret_valid, EX_LS_reg_sret_valid  in  1 each  upstream trap/xret
- EX_LS_reg_trap_cause, EX_LS_reg_trap_tval  in  64 each
- EX_LS_reg_csr_wen, EX_LS_reg_csr_ren  in  1 each;  EX_LS_reg_csr_addr  in  12
- EX_LS_reg_rd  in  5;  EX_LS_reg_dest_wen  in  1;  EX_LS_reg_data  in  64  ALU result / memory address
- EX_LS_reg_load_valid, EX_LS_reg_store_valid  in  1 each
- EX_LS_reg_mem_size  in  2  0=B 1=H 2=W 3=D
- EX_LS_reg_load_unsigned  in  1
- EX_LS_reg_store_data  in  64
- lsu_req_valid  out  1;  lsu_req_ready  in  1
- lsu_req_addr  out  64;  lsu_req_wen  out  1
- lsu_req_wdata  out  64;  lsu_req_wstrb  out  8
- lsu_resp_valid  in  1;  lsu_resp_data  in  64;  lsu_resp_error  in  1
- LS_WB_reg_ls_valid  out  1;  WB_LS_ls_ready  in  1;  WB_LS_flush_flag  in  1
- LS_WB_reg_PC, LS_WB_reg_next_PC  out  64 each;  LS_WB_reg_inst  out  32
- LS_WB_reg_trap_valid, LS_WB_reg_mret_valid, LS_WB_reg_sret_valid  out  1 each
- LS_WB_reg_trap_cause, LS_WB_reg_trap_tval  out  64 each
- LS_WB_reg_csr_wen, LS_WB_reg_csr_ren  out  1 each;  LS_WB_reg_csr_addr  out  12
- LS_WB_reg_rd  out  5;  LS_WB_reg_dest_wen  out  1;  LS_WB_reg_data  out  64

Behaviour:
- Reset: all LS_WB_reg_* = 0 except PC/next_PC = RST_PC. lsu_req_valid=0, wstrb=0, state IDLE.
- Accept: EX_LS_reg_execute_valid & LS_EX_execute_ready & !WB_LS_flush_flag. All fields are captured.
- Accept with no memory op, or with upstream trap_valid: LS_WB_reg_ls_valid=1 next cycle (latency 1); data passes through.
- Misalign check: addr[size-1:0] != 0 (B never misaligned).
  - Load misaligned: trap_valid=1, cause 4, tval=addr, dest_wen=0, no bus request.
  - Store misaligned: same with cause 6.
- Aligned memory op moves to REQ. lsu_req_valid holds with addr, wen, wdata, wstrb stable until lsu_req_ready.
  - wdata = store_data replicated to lane; wstrb = size mask << addr[2:0].
- REQ -> RESP on req_valid & req_ready.
- RESP -> DONE on lsu_resp_valid.
  - Load data = resp_data >> (8*addr[2:0]), sign- or zero-extended per size and unsigned.
  - resp_error: trap cause 5 (load) / 7 (store), tval=addr, dest_wen=0.
- DONE: LS_WB_reg_ls_valid=1. Cleared when WB_LS_ls_ready; then IDLE.
- Flush:
  - In IDLE/DONE: ls_valid cleared next cycle.
  - In REQ before handshake: request dropped, IDLE.
  - In RESP: go to DRAIN, wait for resp_valid, discard response, IDLE. ls_valid is never raised.
- Flush coincident with EX valid: no acceptance.
- Stores never raise dest_wen. The address is not re-presented after acceptance.
- States: IDLE, REQ, RESP, DRAIN; DONE is represented by ls_valid in IDLE.

Optional Feature:
- LSU_STAT_CNT_EN: adds outputs lsu_load_cnt, lsu_store_cnt, lsu_stall_cnt (64 each, reset 0, wrap at 2^64).
  - load/store counters increment once per completed non-faulting access.
  - stall counter increments each cycle in REQ or RESP.
- Without the macro, no ports or logic are present.

Decomposition:
- Shared package: memory-size encodings, trap cause constants (4/5/6/7), state enum.
- Sub-module lsu_load_align: combinational shift/extend of response data by addr[2:0], size, unsigned.

Test Plan:
- LD size=3 addr 0x1000, resp_data 0x8877665544332211 -> LS_WB_reg_data=0x8877665544332211, dest_wen=1, ls_valid 1 cycle after resp.
- LB signed addr 0x1003, resp_data byte3=0x80 -> data 0xFFFFFFFFFFFFFF80; LBU -> 0x80.
- SH addr 0x1006 data 0xABCD -> wstrb=0xC0, wdata[63:48]=0xABCD, dest_wen=0.
- LW addr 0x1002 -> no req_valid, trap_valid=1, cause 4, tval 0x1002.
- req_ready low 3 cycles -> req fields stable, LS_EX_execute_ready=0 throughout.
- Flush in RESP, resp arrives 2 cycles later -> response dropped, ls_valid stays 0, next EX accepted after drain.
